bg_scroll_renderer: RTL and testbench
=====================================

BG_SCROLL_RENDERER -- requirements
Module: bg_scroll_renderer

Interface
REQ-001 Parameter IMG_W, 320, source image width in pixels.
REQ-002 Parameter IMG_H, 240, source image height in pixels.
REQ-003 Parameter SCALE_SH, 1, pixel replication factor 2^SCALE_SH in both axes.
REQ-004 Parameter IDX_W, 4, palette index width returned by the ROM.
REQ-005 Parameter TRANSP_IDX, 0, palette index that marks transparent pixels.
REQ-006 Parameter BORDER_IDX, 0, index substituted for out-of-image pixels when wrap is disabled.
REQ-007 vga_clk  in  1  pixel clock; all logic on the rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 DrawX  in  10  current pixel column, 0..639.
REQ-010 DrawY  in  10  current pixel row, 0..479.
REQ-011 blank  in  1  1 = visible region.
REQ-012 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-013 scroll_load  in  1  one-cycle pulse; captures scroll_in into the pending register.
REQ-014 scroll_in  in  20  {scroll_y[9:0], scroll_x[9:0]}, unsigned.
REQ-015 auto_en  in  1  enables per-frame automatic scrolling.
REQ-016 auto_step  in  8  {dy[3:0], dx[3:0]}, each two's complement, -8..+7.
REQ-017 wrap_en  in  1  1 = toroidal wrap; 0 = out-of-image pixels use BORDER_IDX.
REQ-018 rom_address  out  $clog2(IMG_W*IMG_H)  registered image ROM address.
REQ-019 rom_q  in  IDX_W  ROM data; synchronous read, one cycle after rom_address.
REQ-020 red/green/blue  out  4 each  registered pixel colour.
REQ-021 transparent  out  1  registered; 1 when the final index equals TRANSP_IDX.

Function
REQ-022 The source coordinates SHALL be sx = (DrawX>>SCALE_SH)+scroll_x and sy = (DrawY>>SCALE_SH)+scroll_y, computed at full width without truncation.
REQ-023 In wrap mode, each coordinate SHALL be reduced modulo IMG_W or IMG_H by a single conditional subtraction.
REQ-024 Elaboration SHALL fail unless (640>>SCALE_SH) ≤ IMG_W and (480>>SCALE_SH) ≤ IMG_H.
REQ-025 rom_address SHALL equal sy*IMG_W + sx, registered, valid one cycle after DrawX/DrawY are sampled.
REQ-026 Pipeline: stage 1 registers the address; stage 2 receives rom_q; stage 3 registers the palette output. red/green/blue/transparent SHALL correspond to DrawX/DrawY sampled 3 cycles earlier.
REQ-027 blank and the out-of-image flag SHALL be delayed through matching pipeline stages.
REQ-028 With wrap_en=0 and sx≥IMG_W or sy≥IMG_H, the final index SHALL be BORDER_IDX and the ROM data SHALL be ignored.
REQ-029 When the delayed blank is 0, outputs SHALL be red=green=blue=0 and transparent=0.
REQ-030 The active scroll_x/scroll_y registers SHALL change only on frame_start, so no scroll change occurs mid-frame.
REQ-031 scroll_load SHALL set the pending flag and capture scroll_in; a component ≥ its image dimension SHALL leave that axis's pending value unchanged.
REQ-032 On frame_start with pending set, active scroll SHALL take the pending values, pending SHALL clear, and the auto step SHALL be skipped that frame.
REQ-033 On frame_start with pending clear and auto_en=1, each axis SHALL add its signed step with wrap in both directions (0-1 → IMG_W-1; IMG_W-1+1 → 0).
REQ-034 If scroll_load and frame_start coincide, frame_start SHALL act on the prior pending state, and the new value SHALL be applied at the following frame_start.

Reset
REQ-035 While reset_n=0, all pipeline registers, rom_address, scroll registers, pending flag, red/green/blue and transparent SHALL be 0, taking effect immediately without a clock.
REQ-036 A reset mid-frame SHALL discard any pending load; after release, output is valid 3 cycles later.

Structure
REQ-037 Package bg_render_pkg SHALL hold the rgb444 struct typedef and the default IMG_W/IMG_H/SCALE_SH constants.
REQ-038 One sub-module, bg_palette, SHALL implement the combinational IDX_W→rgb444 lookup used by stage 3.

Verification
REQ-039 Reset, scroll 0, DrawX=10, DrawY=20 → rom_address=3205 after 1 cycle; colour of index rom_q after 3 cycles.
REQ-040 scroll_load with x=318 mid-frame → addresses unchanged until frame_start; then DrawX=8, DrawY=0 → rom_address=2.
REQ-041 scroll_x=0, auto_en=1, dx=-1 → after one frame_start scroll_x=319; at DrawX=0, DrawY=0 → rom_address=319.
REQ-042 wrap_en=0, scroll_x=300, DrawX=60 → BORDER_IDX colour; transparent=1 when BORDER_IDX equals TRANSP_IDX.
REQ-043 rom_q=TRANSP_IDX → transparent=1; blank=0 → rgb=0 and transparent=0, both 3 cycles later.
REQ-044 Load pending, then reset_n pulsed low → outputs 0 asynchronously; the next frame_start leaves scroll at 0,0.

Source files
------------

// File: rtl/bg_render_pkg.sv
// ---------------------------------------------------------------------------
// bg_render_pkg
// Shared types and defaults for the scrolling background renderer.
//   rgb444_t      : packed 4:4:4 colour {r, g, b}
//   DEF_IMG_W/H   : default source image size in pixels
//   DEF_SCALE_SH  : default pixel replication shift (2^SH in both axes)
//   wrap_step()   : adds a signed 4-bit step to a coordinate, wrapping
//                   toroidally into 0..dim-1 (|step| < dim assumed)
// ---------------------------------------------------------------------------
package bg_render_pkg;

  localparam int unsigned DEF_IMG_W    = 320;
  localparam int unsigned DEF_IMG_H    = 240;
  localparam int unsigned DEF_SCALE_SH = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic logic [9:0] wrap_step(input logic [9:0]  cur,
                                           input logic [3:0]  step,
                                           input logic [11:0] dim);
    logic [11:0] sum;
    sum = {2'b00, cur} + {{8{step[3]}}, step};
    // Bit 11 set means the sum went negative (cur < 1024, step >= -8).
    if (sum[11]) begin
      sum = sum + dim;
    end else if (sum >= dim) begin
      sum = sum - dim;
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/bg_palette.sv
// ---------------------------------------------------------------------------
// bg_palette
// Combinational palette lookup: palette index -> rgb444 colour.
// Only the low four index bits select an entry (16-colour table).
//   idx_i : palette index
//   rgb_o : looked-up colour
// ---------------------------------------------------------------------------
module bg_palette
  import bg_render_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  output rgb444_t          rgb_o
);

  logic [3:0] sel;

  always_comb begin
    sel   = 4'(idx_i);
    rgb_o = '0;
    unique case (sel)
      4'h0: rgb_o = '{r: 4'h0, g: 4'h0, b: 4'h0};
      4'h1: rgb_o = '{r: 4'h0, g: 4'h0, b: 4'hA};
      4'h2: rgb_o = '{r: 4'h0, g: 4'hA, b: 4'h0};
      4'h3: rgb_o = '{r: 4'h0, g: 4'hA, b: 4'hA};
      4'h4: rgb_o = '{r: 4'hA, g: 4'h0, b: 4'h0};
      4'h5: rgb_o = '{r: 4'hA, g: 4'h0, b: 4'hA};
      4'h6: rgb_o = '{r: 4'hA, g: 4'h5, b: 4'h0};
      4'h7: rgb_o = '{r: 4'hA, g: 4'hA, b: 4'hA};
      4'h8: rgb_o = '{r: 4'h5, g: 4'h5, b: 4'h5};
      4'h9: rgb_o = '{r: 4'h5, g: 4'h5, b: 4'hF};
      4'hA: rgb_o = '{r: 4'h5, g: 4'hF, b: 4'h5};
      4'hB: rgb_o = '{r: 4'h5, g: 4'hF, b: 4'hF};
      4'hC: rgb_o = '{r: 4'hF, g: 4'h5, b: 4'h5};
      4'hD: rgb_o = '{r: 4'hF, g: 4'h5, b: 4'hF};
      4'hE: rgb_o = '{r: 4'hF, g: 4'hF, b: 4'h5};
      4'hF: rgb_o = '{r: 4'hF, g: 4'hF, b: 4'hF};
      default: rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/bg_scroll_renderer.sv
// ---------------------------------------------------------------------------
// bg_scroll_renderer
// Renders a scrolled, pixel-replicated background image from an external
// synchronous-read palette-index ROM. Three-cycle pipeline:
//   stage 1: source coordinate + ROM address registered
//   stage 2: ROM returns the index (rom_q)
//   stage 3: palette lookup registered onto red/green/blue/transparent
// Scroll offsets update only on frame_start, either from a pending load or
// from a per-frame signed auto step.
// Ports:
//   vga_clk, reset_n          : pixel clock, async active-low reset
//   DrawX, DrawY, blank       : current raster position, 1 = visible
//   frame_start               : one-cycle pulse at frame start
//   scroll_load, scroll_in    : load {y, x} into the pending register
//   auto_en, auto_step        : per-frame auto scroll, {dy, dx} signed
//   wrap_en                   : 1 = toroidal wrap, 0 = border index
//   rom_address, rom_q        : image ROM interface
//   red, green, blue          : registered output colour
//   transparent               : final index equals TRANSP_IDX
// ---------------------------------------------------------------------------
module bg_scroll_renderer
  import bg_render_pkg::*;
#(
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H,
  parameter int unsigned SCALE_SH   = DEF_SCALE_SH,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned BORDER_IDX = 0,
  localparam int unsigned ADDR_W    = $clog2(IMG_W * IMG_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              scroll_load,
  input  logic [19:0]       scroll_in,
  input  logic              auto_en,
  input  logic [7:0]        auto_step,
  input  logic              wrap_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              transparent
);

  localparam logic [11:0] IMG_W12 = 12'(IMG_W);
  localparam logic [11:0] IMG_H12 = 12'(IMG_H);

  if (((640 >> SCALE_SH) > IMG_W) || ((480 >> SCALE_SH) > IMG_H)) begin : g_bad_size
    $error("bg_scroll_renderer: scaled screen exceeds image size");
  end

  // ---------------- scroll registers ----------------
  logic       pending_q, pending_d;
  logic [9:0] pend_x_q, pend_x_d;
  logic [9:0] pend_y_q, pend_y_d;
  logic [9:0] scroll_x_q, scroll_x_d;
  logic [9:0] scroll_y_q, scroll_y_d;

  // frame_start sees the registered (prior) pending state, so a load in the
  // same cycle lands in pend_*_d and is applied at the next frame_start.
  always_comb begin
    pending_d  = pending_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;

    if (frame_start) begin
      if (pending_q) begin
        scroll_x_d = pend_x_q;
        scroll_y_d = pend_y_q;
        pending_d  = 1'b0;
      end else if (auto_en) begin
        scroll_x_d = wrap_step(scroll_x_q, auto_step[3:0], IMG_W12);
        scroll_y_d = wrap_step(scroll_y_q, auto_step[7:4], IMG_H12);
      end
    end

    if (scroll_load) begin
      pending_d = 1'b1;
      if ({2'b00, scroll_in[9:0]} < IMG_W12) begin
        pend_x_d = scroll_in[9:0];
      end
      if ({2'b00, scroll_in[19:10]} < IMG_H12) begin
        pend_y_d = scroll_in[19:10];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      scroll_x_q <= '0;
      scroll_y_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
    end
  end

  // ---------------- stage 1: address ----------------
  logic [11:0]       sx_raw, sy_raw, sx, sy;
  logic              oob_d;
  logic [ADDR_W-1:0] rom_address_d;

  always_comb begin
    sx_raw = {2'b00, DrawX >> SCALE_SH} + {2'b00, scroll_x_q};
    sy_raw = {2'b00, DrawY >> SCALE_SH} + {2'b00, scroll_y_q};
    sx     = sx_raw;
    sy     = sy_raw;
    oob_d  = 1'b0;
    if (wrap_en) begin
      if (sx_raw >= IMG_W12) sx = sx_raw - IMG_W12;
      if (sy_raw >= IMG_H12) sy = sy_raw - IMG_H12;
    end else begin
      oob_d = (sx_raw >= IMG_W12) || (sy_raw >= IMG_H12);
    end
    rom_address_d = ADDR_W'(32'(sy) * IMG_W + 32'(sx));
  end

  logic blank_s1_q, oob_s1_q;
  logic blank_s2_q, oob_s2_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      blank_s1_q  <= 1'b0;
      oob_s1_q    <= 1'b0;
      blank_s2_q  <= 1'b0;
      oob_s2_q    <= 1'b0;
    end else begin
      rom_address <= rom_address_d;
      blank_s1_q  <= blank;
      oob_s1_q    <= oob_d;
      blank_s2_q  <= blank_s1_q;
      oob_s2_q    <= oob_s1_q;
    end
  end

  // ---------------- stage 3: palette ----------------
  logic [IDX_W-1:0] idx_fin;
  rgb444_t          pal_rgb;
  rgb444_t          rgb_d;
  logic             transp_d;

  assign idx_fin = oob_s2_q ? IDX_W'(BORDER_IDX) : rom_q;

  bg_palette #(.IDX_W(IDX_W)) u_palette (
    .idx_i (idx_fin),
    .rgb_o (pal_rgb)
  );

  always_comb begin
    rgb_d    = '0;
    transp_d = 1'b0;
    if (blank_s2_q) begin
      rgb_d    = pal_rgb;
      transp_d = (idx_fin == IDX_W'(TRANSP_IDX));
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
    end else begin
      red         <= rgb_d.r;
      green       <= rgb_d.g;
      blue        <= rgb_d.b;
      transparent <= transp_d;
    end
  end

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// ---------------------------------------------------------------------------
// tb_bg_scroll_renderer
// Directed bench for bg_scroll_renderer at 320x240, scale 2. The image ROM
// is modelled as a synchronous read returning the low nibble of the address.
// ---------------------------------------------------------------------------
module tb_bg_scroll_renderer;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start, scroll_load, auto_en, wrap_en;
  logic [19:0] scroll_in;
  logic [7:0]  auto_step;
  logic [16:0] rom_address;
  logic [3:0]  rom_q = '0;
  logic [3:0]  red, green, blue;
  logic        transparent;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA,
                            12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                            12'h555, 12'h55F, 12'h5F5, 12'h5FF,
                            12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom_address[3:0];

  bg_scroll_renderer #(
    .IMG_W(320), .IMG_H(240), .SCALE_SH(1), .IDX_W(4),
    .TRANSP_IDX(0), .BORDER_IDX(0)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .scroll_load(scroll_load),
    .scroll_in(scroll_in), .auto_en(auto_en), .auto_step(auto_step),
    .wrap_en(wrap_en), .rom_address(rom_address), .rom_q(rom_q),
    .red(red), .green(green), .blue(blue), .transparent(transparent)
  );

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  // Loads {y, x} and applies it at the following frame_start.
  task automatic load_and_apply(input int x, input int y);
    scroll_in   = {10'(y), 10'(x)};
    scroll_load = 1'b1;
    tick();
    scroll_load = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (rom_address !== 17'd0) begin
      errors++; $display("FAIL reset_addr: got %0d expected 0", rom_address);
    end
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
    end
    checks++;
    if (transparent !== 1'b0) begin
      errors++; $display("FAIL reset_transp: got %b expected 0", transparent);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_pix(10, 20);
    tick();
    checks++;
    if (rom_address !== 17'd3205) begin
      errors++; $display("FAIL basic_addr: got %0d expected 3205", rom_address);
    end
    tick(); tick();
    checks++;
    if ({red, green, blue} !== pal[5] || transparent !== 1'b0) begin
      errors++; $display("FAIL basic_rgb: got %h/%b expected %h/0", {red, green, blue}, transparent, pal[5]);
    end
    set_pix(639, 479);
    tick();
    checks++;
    if (rom_address !== 17'd76799) begin
      errors++; $display("FAIL corner_addr: got %0d expected 76799", rom_address);
    end
    tick(); tick();
    checks++;
    if ({red, green, blue} !== pal[15]) begin
      errors++; $display("FAIL corner_rgb: got %h expected %h", {red, green, blue}, pal[15]);
    end
  endtask

  // One pixel per clock; each output lags its sample by three clocks.
  task automatic test_back_to_back();
    for (int k = 0; k < 18; k++) begin
      set_pix(2 * k, 0);
      tick();
      if (k >= 2) begin
        checks++;
        if ({red, green, blue} !== pal[k-2] || transparent !== (k == 2)) begin
          errors++;
          $display("FAIL stream_%0d: got %h/%b expected %h/%b", k - 2,
                   {red, green, blue}, transparent, pal[k-2], (k == 2));
        end
      end
    end
  endtask

  task automatic test_scroll_load();
    scroll_in   = {10'd0, 10'd318};
    scroll_load = 1'b1;
    set_pix(8, 0);
    tick();
    scroll_load = 1'b0;
    checks++;
    if (rom_address !== 17'd4) begin
      errors++; $display("FAIL load_pending_addr: got %0d expected 4", rom_address);
    end
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (rom_address !== 17'd4) begin
      errors++; $display("FAIL load_fs_edge_addr: got %0d expected 4", rom_address);
    end
    tick();
    checks++;
    if (rom_address !== 17'd2) begin
      errors++; $display("FAIL load_applied_addr: got %0d expected 2", rom_address);
    end
    // x=400 is out of range and must leave pending x at 318; y=5 accepted.
    load_and_apply(400, 5);
    set_pix(0, 0);
    tick();
    checks++;
    if (rom_address !== 17'd1918) begin
      errors++; $display("FAIL load_reject_addr: got %0d expected 1918", rom_address);
    end
  endtask

  task automatic test_auto();
    load_and_apply(0, 0);
    auto_en     = 1'b1;
    auto_step   = 8'h0F;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    auto_en     = 1'b0;
    set_pix(0, 0);
    tick();
    checks++;
    if (rom_address !== 17'd319) begin
      errors++; $display("FAIL auto_dx_neg_addr: got %0d expected 319", rom_address);
    end
    auto_en     = 1'b1;
    auto_step   = 8'hF1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    auto_en     = 1'b0;
    tick();
    checks++;
    if (rom_address !== 17'd76480) begin
      errors++; $display("FAIL auto_wrap_xy_addr: got %0d expected 76480", rom_address);
    end
    // Load coinciding with frame_start: no change now, applied next frame.
    scroll_in   = {10'd0, 10'd7};
    scroll_load = 1'b1;
    frame_start = 1'b1;
    tick();
    scroll_load = 1'b0;
    frame_start = 1'b0;
    tick();
    checks++;
    if (rom_address !== 17'd76480) begin
      errors++; $display("FAIL coincide_hold_addr: got %0d expected 76480", rom_address);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++;
    if (rom_address !== 17'd7) begin
      errors++; $display("FAIL coincide_apply_addr: got %0d expected 7", rom_address);
    end
  endtask

  task automatic test_border();
    wrap_en = 1'b0;
    load_and_apply(300, 0);
    set_pix(60, 0);
    tick(); tick(); tick();
    checks++;
    if ({red, green, blue} !== 12'h000 || transparent !== 1'b1) begin
      errors++; $display("FAIL border_rgb: got %h/%b expected 000/1", {red, green, blue}, transparent);
    end
    set_pix(0, 0);
    tick(); tick(); tick();
    checks++;
    if ({red, green, blue} !== pal[12] || transparent !== 1'b0) begin
      errors++; $display("FAIL nowrap_inside_rgb: got %h/%b expected %h/0", {red, green, blue}, transparent, pal[12]);
    end
    wrap_en = 1'b1;
    set_pix(60, 0);
    tick();
    checks++;
    if (rom_address !== 17'd10) begin
      errors++; $display("FAIL wrap_x_addr: got %0d expected 10", rom_address);
    end
    tick(); tick();
    checks++;
    if ({red, green, blue} !== pal[10]) begin
      errors++; $display("FAIL wrap_x_rgb: got %h expected %h", {red, green, blue}, pal[10]);
    end
  endtask

  task automatic test_transparent();
    load_and_apply(0, 0);
    set_pix(32, 0);
    tick(); tick(); tick();
    checks++;
    if (transparent !== 1'b1 || {red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL transp_idx: got %h/%b expected 000/1", {red, green, blue}, transparent);
    end
    blank = 1'b0;
    set_pix(10, 0);
    tick();
    blank = 1'b1;
    set_pix(12, 0);
    tick();
    checks++;
    if (transparent !== 1'b1) begin
      errors++; $display("FAIL blank_lag_transp: got %b expected 1", transparent);
    end
    tick();
    checks++;
    if ({red, green, blue} !== 12'h000 || transparent !== 1'b0) begin
      errors++; $display("FAIL blank_rgb: got %h/%b expected 000/0", {red, green, blue}, transparent);
    end
    tick();
    checks++;
    if ({red, green, blue} !== pal[6]) begin
      errors++; $display("FAIL unblank_rgb: got %h expected %h", {red, green, blue}, pal[6]);
    end
  endtask

  task automatic test_reset_pending();
    set_pix(10, 0);
    scroll_in   = {10'd10, 10'd50};
    scroll_load = 1'b1;
    tick();
    scroll_load = 1'b0;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== pal[5]) begin
      errors++; $display("FAIL prereset_rgb: got %h expected %h", {red, green, blue}, pal[5]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rom_address !== 17'd0 || {red, green, blue} !== 12'h000 || transparent !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got addr=%0d rgb=%h t=%b expected 0/000/0",
               rom_address, {red, green, blue}, transparent);
    end
    tick();
    reset_n     = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    set_pix(20, 0);
    tick();
    checks++;
    if (rom_address !== 17'd10) begin
      errors++; $display("FAIL reset_drops_pending: got %0d expected 10", rom_address);
    end
    tick(); tick();
    checks++;
    if ({red, green, blue} !== pal[10]) begin
      errors++; $display("FAIL postreset_rgb: got %h expected %h", {red, green, blue}, pal[10]);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    blank       = 1'b1;
    frame_start = 1'b0;
    scroll_load = 1'b0;
    scroll_in   = '0;
    auto_en     = 1'b0;
    auto_step   = '0;
    wrap_en     = 1'b1;

    test_reset();
    test_basic();
    test_back_to_back();
    test_scroll_load();
    test_auto();
    test_border();
    test_transparent();
    test_reset_pending();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
